// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: instruction classes, major opcodes and the canonical NOP.
// The control-unit decoder imports this same package.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    CLS_OPIMM  = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_OP     = 3'd2,
    CLS_JAL    = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_LUI    = 3'd5,
    CLS_BRANCH = 3'd6,
    CLS_RSVD   = 3'd7
  } iclass_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [6:0] opcode_of(iclass_e c);
    case (c)
      CLS_OPIMM:  opcode_of = OPC_OPIMM;
      CLS_LOAD:   opcode_of = OPC_LOAD;
      CLS_OP:     opcode_of = OPC_OP;
      CLS_JAL:    opcode_of = OPC_JAL;
      CLS_STORE:  opcode_of = OPC_STORE;
      CLS_LUI:    opcode_of = OPC_LUI;
      CLS_BRANCH: opcode_of = OPC_BRANCH;
      default:    opcode_of = OPC_OPIMM;
    endcase
  endfunction

endpackage

// File: rtl/enc_imm_pack.sv
// Scatters a byte-offset / upper immediate into its RV32I format bit positions.
// Bits not owned by the class's immediate are left zero so the top can OR fields in.
module enc_imm_pack
  import instr_encoder_pkg::*;
(
  input  iclass_e     iclass_i,
  input  logic [31:0] imm_i,
  output logic [31:0] imm_bits_o
);

  always_comb begin
    imm_bits_o = '0;
    case (iclass_i)
      CLS_OPIMM, CLS_LOAD: begin
        imm_bits_o[31:20] = imm_i[11:0];
      end
      CLS_STORE: begin
        imm_bits_o[31:25] = imm_i[11:5];
        imm_bits_o[11:7]  = imm_i[4:0];
      end
      CLS_BRANCH: begin
        imm_bits_o[31]    = imm_i[12];
        imm_bits_o[30:25] = imm_i[10:5];
        imm_bits_o[11:8]  = imm_i[4:1];
        imm_bits_o[7]     = imm_i[11];
      end
      CLS_LUI: begin
        imm_bits_o[31:12] = imm_i[31:12];
      end
      CLS_JAL: begin
        imm_bits_o[31]    = imm_i[20];
        imm_bits_o[30:21] = imm_i[10:1];
        imm_bits_o[20]    = imm_i[11];
        imm_bits_o[19:12] = imm_i[19:12];
      end
      default: imm_bits_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a single output register stage and a byte write pointer.
// Optional immediate range checking is compiled in with ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        iclass,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic              err_range
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  iclass_e           cls;
  logic [31:0]       imm_bits;
  logic [31:0]       fields;
  logic [31:0]       enc_word;
  logic              accept;
  logic              xfer;

  logic              valid_q, valid_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ill_q, ill_d;

  assign cls = iclass_e'(iclass);

  enc_imm_pack u_imm_pack (
    .iclass_i   (cls),
    .imm_i      (imm),
    .imm_bits_o (imm_bits)
  );

  // Register fields per format; anything the format does not own stays zero.
  always_comb begin
    fields = '0;
    case (cls)
      CLS_OPIMM, CLS_LOAD:   fields = {12'd0, rs1, funct3, rd, 7'd0};
      CLS_OP:                fields = {funct7, rs2, rs1, funct3, rd, 7'd0};
      CLS_STORE, CLS_BRANCH: fields = {7'd0, rs2, rs1, funct3, 5'd0, 7'd0};
      CLS_LUI, CLS_JAL:      fields = {20'd0, rd, 7'd0};
      default:               fields = '0;
    endcase
    if (cls == CLS_RSVD) begin
      enc_word = NOP_WORD;
    end else begin
      enc_word = fields | imm_bits | {25'd0, opcode_of(cls)};
    end
  end

  assign in_ready = !clear && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready && !clear;

  // A word accepted alongside a transfer lands one slot past the word leaving.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    ill_d   = ill_q;
    if (clear) begin
      valid_d = 1'b0;
      ptr_d   = ADDR_BASE;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
        ptr_d   = ptr_q + ADDR_STEP;
      end
      if (accept) begin
        valid_d = 1'b1;
        word_d  = enc_word;
        addr_d  = xfer ? (ptr_q + ADDR_STEP) : ptr_q;
        if (cls == CLS_RSVD) ill_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      addr_q  <= ADDR_BASE;
      ptr_q   <= ADDR_BASE;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_word    = word_q;
  assign out_addr    = addr_q;
  assign err_illegal = ill_q;

`ifdef ENC_RANGE_CHECK_EN
  logic rng_q, rng_d;

  function automatic logic imm_out_of_range(iclass_e c, logic [31:0] v);
    logic signed [31:0] s;
    s = $signed(v);
    case (c)
      CLS_OPIMM, CLS_LOAD, CLS_STORE:
        imm_out_of_range = (s < -32'sd2048) || (s > 32'sd2047);
      CLS_BRANCH:
        imm_out_of_range = (s < -32'sd4096) || (s > 32'sd4094) || v[0];
      CLS_JAL:
        imm_out_of_range = (s < -32'sd1048576) || (s > 32'sd1048574) || v[0];
      CLS_LUI:
        imm_out_of_range = (v[11:0] != 12'd0);
      default:
        imm_out_of_range = 1'b0;
    endcase
  endfunction

  always_comb begin
    rng_d = rng_q;
    if (accept && imm_out_of_range(cls, imm)) rng_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rng_q <= 1'b0;
    else     rng_q <= rng_d;
  end

  assign err_range = rng_q;
`else
  assign err_range = 1'b0;
`endif

endmodule
